// File: rtl/lock_ctrl_gen_if.sv
// Keypad/switch inputs and display/LED outputs shared by the lock controller
// and whatever drives it; the controller takes the slave side.
interface lock_ctrl_gen_if #(
    parameter int DIGITS  = 6,
    parameter int SLOTS   = 4,
    parameter int MAX_ERR = 3
);
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int EW = $clog2(MAX_ERR + 1);

    logic              mode;
    logic [SW-1:0]     slot;
    logic [3:0]        digit;
    logic              digit_vld;
    logic              clr;
    logic              enter;
    logic [4*DIGITS-1:0] disp;
    logic              unlock;
    logic              locked;
    logic              alarm;
    logic [EW-1:0]     err_cnt;
    logic              prog_ok;

    modport master (
        output mode, slot, digit, digit_vld, clr, enter,
        input  disp, unlock, locked, alarm, err_cnt, prog_ok
    );

    modport slave (
        input  mode, slot, digit, digit_vld, clr, enter,
        output disp, unlock, locked, alarm, err_cnt, prog_ok
    );
endinterface

// File: rtl/lock_ctrl_gen.sv
// Multi-slot electronic lock: BCD entry buffer, gated password programming,
// failure counting with a timed, flashing lockout.
module lock_ctrl_gen #(
    parameter int DIGITS      = 6,
    parameter int SLOTS       = 4,
    parameter int MAX_ERR     = 3,
    parameter int OPEN_CYCLES = 256,
    parameter int LOCK_CYCLES = 1024,
    parameter int FLASH_HALF  = 16
) (
    input logic            clk,
    input logic            clr_n,
    lock_ctrl_gen_if.slave bus
);
    localparam int BW   = 4 * DIGITS;
    localparam int EW   = $clog2(MAX_ERR + 1);
    localparam int CW   = $clog2(DIGITS + 1);
    localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(FLASH_HALF + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   entry_q, entry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [FW-1:0]   flash_q, flash_d;
    logic            alarm_q, alarm_d;
    logic [EW-1:0]   err_q, err_d;
    logic [BW-1:0]   word_q [SLOTS];
    logic [SLOTS-1:0] valid_q;
    logic [BW-1:0]   disp_q;
    logic            unlock_q, locked_q, prog_q;
    logic            wr_en, full, slot_ok, write_ok, match;
    logic [31:0]     slot_ext, err_inc;

    assign slot_ext = 32'(bus.slot);
    assign full     = (cnt_q == CW'(DIGITS));
    assign slot_ok  = (slot_ext < 32'(SLOTS));
    assign err_inc  = 32'(err_q) + 32'd1;
    // Programming is only trusted while open, or while the lock has no password at all.
    assign write_ok = full && slot_ok && ((state_q == OPEN) || (valid_q == '0));

    always_comb begin
        match = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (full && valid_q[i] && (word_q[i] == entry_q)) begin
                match = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        flash_d = flash_q;
        alarm_d = alarm_q;
        err_d   = err_q;
        wr_en   = 1'b0;

        case (state_q)
            IDLE, OPEN: begin
                if (state_q == OPEN) begin
                    if (timer_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end

                // clr outranks enter, and enter swallows a same-cycle digit.
                if (bus.clr) begin
                    entry_d = '0;
                    cnt_d   = '0;
                end else if (bus.enter) begin
                    if (!bus.mode) begin
                        if (write_ok) begin
                            wr_en   = 1'b1;
                            entry_d = '0;
                            cnt_d   = '0;
                        end
                    end else if (state_q == IDLE) begin
                        entry_d = '0;
                        cnt_d   = '0;
                        if (match) begin
                            state_d = OPEN;
                            timer_d = TW'(OPEN_CYCLES - 1);
                            err_d   = '0;
                        end else if (err_inc >= 32'(MAX_ERR)) begin
                            err_d   = EW'(MAX_ERR);
                            state_d = LOCKOUT;
                            timer_d = TW'(LOCK_CYCLES - 1);
                            flash_d = FW'(FLASH_HALF - 1);
                            alarm_d = 1'b1;
                        end else begin
                            err_d = EW'(err_inc);
                        end
                    end else begin
                        state_d = IDLE;
                        entry_d = '0;
                        cnt_d   = '0;
                    end
                end else if (bus.digit_vld && (bus.digit <= 4'd9) && !full) begin
                    entry_d = {entry_q[BW-5:0], bus.digit};
                    cnt_d   = cnt_q + 1'b1;
                end
            end

            LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                    err_d   = '0;
                    alarm_d = 1'b0;
                    entry_d = '0;
                    cnt_d   = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                    if (flash_q == '0) begin
                        alarm_d = ~alarm_q;
                        flash_d = FW'(FLASH_HALF - 1);
                    end else begin
                        flash_d = flash_q - 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they land the cycle after the cause.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= IDLE;
            entry_q  <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            flash_q  <= '0;
            alarm_q  <= 1'b0;
            err_q    <= '0;
            disp_q   <= '0;
            unlock_q <= 1'b0;
            locked_q <= 1'b0;
            prog_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            entry_q  <= entry_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            flash_q  <= flash_d;
            alarm_q  <= alarm_d;
            err_q    <= err_d;
            disp_q   <= (state_d == LOCKOUT) ? {DIGITS{4'hE}} : entry_d;
            unlock_q <= (state_d == OPEN);
            locked_q <= (state_d == LOCKOUT);
            prog_q   <= wr_en;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                word_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (wr_en && (slot_ext == 32'(i))) begin
                    word_q[i]  <= entry_q;
                    valid_q[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.disp    = disp_q;
    assign bus.unlock  = unlock_q;
    assign bus.locked  = locked_q;
    assign bus.alarm   = alarm_q;
    assign bus.err_cnt = err_q;
    assign bus.prog_ok = prog_q;
endmodule

// File: tb/tb_lock_ctrl_gen.sv
// Bench for lock_ctrl_gen: directed vector table, timing sequences, resets and
// random traffic, all scored against a queue-based model of the lock.
module tb_lock_ctrl_gen;
    localparam int D  = 6;
    localparam int NS = 4;
    localparam int ME = 3;
    localparam int OC = 256;
    localparam int LC = 1024;
    localparam int FH = 16;

    logic clk = 1'b0;
    logic clr_n;
    always #5 clk = ~clk;

    lock_ctrl_gen_if #(.DIGITS(D), .SLOTS(NS), .MAX_ERR(ME)) bus();

    lock_ctrl_gen #(
        .DIGITS(D), .SLOTS(NS), .MAX_ERR(ME),
        .OPEN_CYCLES(OC), .LOCK_CYCLES(LC), .FLASH_HALF(FH)
    ) dut (
        .clk(clk),
        .clr_n(clr_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Model: 0 idle, 1 open, 2 lockout; elapsed counts edges spent in the current timed state.
    int             m_state;
    int             m_elapsed;
    int             m_err;
    bit             m_prog;
    int             m_q[$];
    logic [4*D-1:0] m_slot [NS];
    bit             m_valid [NS];

    typedef struct {
        bit         mode;
        int         slot;
        int         digit;
        bit         dvld;
        bit         clr;
        bit         enter;
        logic [23:0] e_disp;
        bit         e_unlock;
        bit         e_prog;
        int         e_err;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [4*D-1:0] q_word();
        logic [4*D-1:0] w = '0;
        foreach (m_q[i]) w = {w[4*D-5:0], 4'(m_q[i])};
        return w;
    endfunction

    task automatic model_reset();
        m_state = 0; m_elapsed = 0; m_err = 0; m_prog = 0;
        m_q.delete();
        for (int i = 0; i < NS; i++) begin m_slot[i] = '0; m_valid[i] = 0; end
    endtask

    task automatic model_step(input bit mode, input int slot, input int digit,
                              input bit dvld, input bit clr, input bit enter);
        int pre;
        bit any_valid;
        bit hit;
        pre = m_state;
        m_prog = 0;
        if (pre == 2) begin
            m_elapsed++;
            if (m_elapsed == LC) begin m_state = 0; m_err = 0; m_q.delete(); end
            return;
        end
        if (pre == 1) begin
            m_elapsed++;
            if (m_elapsed == OC) m_state = 0;
        end
        if (clr) begin
            m_q.delete();
        end else if (enter) begin
            if (!mode) begin
                any_valid = 0;
                foreach (m_valid[i]) any_valid |= m_valid[i];
                if (m_q.size() == D && (pre == 1 || !any_valid) && slot < NS) begin
                    m_slot[slot] = q_word(); m_valid[slot] = 1; m_prog = 1; m_q.delete();
                end
            end else if (pre == 0) begin
                hit = 0;
                if (m_q.size() == D)
                    foreach (m_slot[i]) if (m_valid[i] && m_slot[i] == q_word()) hit = 1;
                m_q.delete();
                if (hit) begin
                    m_state = 1; m_elapsed = 0; m_err = 0;
                end else begin
                    if (m_err < ME) m_err++;
                    if (m_err == ME) begin m_state = 2; m_elapsed = 0; end
                end
            end else begin
                m_state = 0;
                m_q.delete();
            end
        end else if (dvld && digit <= 9 && m_q.size() < D) begin
            m_q.push_back(digit);
        end
    endtask

    task automatic cmp(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s.%s got %0h expected %0h at %0t", tag, name, act, exp, $time);
        end
    endtask

    task automatic check_output(input string tag);
        logic [4*D-1:0] ed;
        ed = (m_state == 2) ? {D{4'hE}} : q_word();
        cmp(tag, "disp",    32'(bus.disp),    32'(ed));
        cmp(tag, "unlock",  32'(bus.unlock),  32'(m_state == 1));
        cmp(tag, "locked",  32'(bus.locked),  32'(m_state == 2));
        cmp(tag, "alarm",   32'(bus.alarm),   32'(m_state == 2 && ((m_elapsed / FH) % 2 == 0)));
        cmp(tag, "err_cnt", 32'(bus.err_cnt), 32'(m_err));
        cmp(tag, "prog_ok", 32'(bus.prog_ok), 32'(m_prog));
    endtask

    task automatic apply_stimulus(input string tag, input bit mode, input int slot, input int digit,
                                  input bit dvld, input bit clr, input bit enter);
        bus.mode = mode; bus.slot = 2'(slot); bus.digit = 4'(digit);
        bus.digit_vld = dvld; bus.clr = clr; bus.enter = enter;
        @(posedge clk);
        model_step(mode, slot, digit, dvld, clr, enter);
        #1;
        bus.digit_vld = 1'b0; bus.clr = 1'b0; bus.enter = 1'b0;
        check_output(tag);
    endtask

    task automatic type_code(input string tag, input bit mode, input int slot, input logic [23:0] code, input int n);
        for (int k = n - 1; k >= 0; k--)
            apply_stimulus(tag, mode, slot, int'((code >> (4 * k)) & 24'hF), 1'b1, 1'b0, 1'b0);
    endtask

    task automatic press(input string tag, input bit mode, input int slot);
        apply_stimulus(tag, mode, slot, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input string tag);
        #2;
        clr_n = 1'b0;
        #1;
        model_reset();
        check_output(tag);
        @(posedge clk); #1;
        check_output(tag);
        @(negedge clk);
        clr_n = 1'b1;
    endtask

    task automatic add_vec(input bit mode, input int slot, input int digit, input bit dvld, input bit clr,
                           input bit enter, input logic [23:0] e_disp, input bit e_unlock, input bit e_prog,
                           input int e_err);
        vec_t v;
        v.mode = mode; v.slot = slot; v.digit = digit; v.dvld = dvld; v.clr = clr; v.enter = enter;
        v.e_disp = e_disp; v.e_unlock = e_unlock; v.e_prog = e_prog; v.e_err = e_err;
        tbl.push_back(v);
    endtask

    task automatic add_code(input bit mode, input int slot, input logic [23:0] code, input int n,
                            input bit e_unlock, input int e_err);
        for (int k = n - 1; k >= 0; k--)
            add_vec(mode, slot, int'((code >> (4 * k)) & 24'hF), 1, 0, 0, code >> (4 * k), e_unlock, 0, e_err);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int open_len, lock_len, alarm_hi;

        // First password, with an out-of-range digit and an overflow digit thrown in.
        add_vec(0, 0, 1,  1, 0, 0, 24'h000001, 0, 0, 0);
        add_vec(0, 0, 2,  1, 0, 0, 24'h000012, 0, 0, 0);
        add_vec(0, 0, 10, 1, 0, 0, 24'h000012, 0, 0, 0);
        add_vec(0, 0, 3,  1, 0, 0, 24'h000123, 0, 0, 0);
        add_vec(0, 0, 4,  1, 0, 0, 24'h001234, 0, 0, 0);
        add_vec(0, 0, 5,  1, 0, 0, 24'h012345, 0, 0, 0);
        add_vec(0, 0, 6,  1, 0, 0, 24'h123456, 0, 0, 0);
        add_vec(0, 0, 7,  1, 0, 0, 24'h123456, 0, 0, 0);
        add_vec(0, 0, 0,  0, 0, 1, 24'h000000, 0, 1, 0);
        add_vec(0, 0, 0,  0, 0, 0, 24'h000000, 0, 0, 0);
        add_code(1, 0, 24'h654321, 6, 0, 0);
        add_vec(1, 0, 0,  0, 0, 1, 24'h000000, 0, 0, 1);
        add_code(1, 0, 24'h123456, 6, 0, 1);
        add_vec(1, 0, 9,  1, 0, 1, 24'h000000, 1, 0, 0);
        add_code(0, 1, 24'h654321, 6, 1, 0);
        add_vec(0, 1, 0,  0, 0, 1, 24'h000000, 1, 1, 0);
        add_vec(1, 0, 0,  0, 0, 1, 24'h000000, 0, 0, 0);
        add_code(1, 0, 24'h654321, 6, 0, 0);
        add_vec(1, 0, 0,  0, 0, 1, 24'h000000, 1, 0, 0);
        add_vec(1, 0, 0,  0, 0, 1, 24'h000000, 0, 0, 0);
        add_vec(1, 0, 1,  1, 0, 0, 24'h000001, 0, 0, 0);
        add_vec(1, 0, 2,  1, 0, 0, 24'h000012, 0, 0, 0);
        add_vec(1, 0, 3,  1, 1, 1, 24'h000000, 0, 0, 0);

        bus.mode = 1'b0; bus.slot = '0; bus.digit = '0;
        bus.digit_vld = 1'b0; bus.clr = 1'b0; bus.enter = 1'b0;
        clr_n = 1'b1;
        #1;
        clr_n = 1'b0;
        model_reset();
        @(posedge clk); #1;
        check_output("reset");
        @(negedge clk);
        clr_n = 1'b1;

        foreach (tbl[i]) begin
            apply_stimulus("tbl", tbl[i].mode, tbl[i].slot, tbl[i].digit, tbl[i].dvld, tbl[i].clr, tbl[i].enter);
            cmp($sformatf("tbl%0d", i), "disp",   32'(bus.disp),    32'(tbl[i].e_disp));
            cmp($sformatf("tbl%0d", i), "unlock", 32'(bus.unlock),  32'(tbl[i].e_unlock));
            cmp($sformatf("tbl%0d", i), "prog",   32'(bus.prog_ok), 32'(tbl[i].e_prog));
            cmp($sformatf("tbl%0d", i), "err",    32'(bus.err_cnt), 32'(tbl[i].e_err));
        end

        // Unlock must hold for exactly OC cycles.
        type_code("open", 1, 0, 24'h123456, 6);
        press("open", 1, 0);
        open_len = bus.unlock ? 1 : 0;
        for (int g = 0; g < 300 && bus.unlock; g++) begin
            apply_stimulus("open", 1, 0, 0, 0, 0, 0);
            if (bus.unlock) open_len++;
        end
        cmp("open", "open_len", 32'(open_len), 32'(OC));

        // Programming while idle with valid slots is refused and leaves the buffer alone.
        type_code("idle_prog", 0, 2, 24'h111111, 6);
        press("idle_prog", 0, 2);
        cmp("idle_prog", "prog", 32'(bus.prog_ok), 32'd0);
        cmp("idle_prog", "disp", 32'(bus.disp), 32'h111111);
        apply_stimulus("idle_prog", 0, 0, 0, 0, 1, 0);

        // Short entry counts as a failure, then two wrong codes lock out.
        type_code("fail", 1, 0, 24'h012345, 5);
        press("fail", 1, 0);
        cmp("fail", "err_short", 32'(bus.err_cnt), 32'd1);
        type_code("fail", 1, 0, 24'h111111, 6);
        press("fail", 1, 0);
        cmp("fail", "err2", 32'(bus.err_cnt), 32'd2);
        type_code("fail", 1, 0, 24'h111111, 6);
        press("fail", 1, 0);
        cmp("fail", "err3", 32'(bus.err_cnt), 32'd3);
        cmp("fail", "locked", 32'(bus.locked), 32'd1);
        cmp("fail", "disp_e", 32'(bus.disp), 32'hEEEEEE);

        lock_len = bus.locked ? 1 : 0;
        alarm_hi = bus.alarm ? 1 : 0;
        for (int g = 0; g < 1100 && bus.locked; g++) begin
            apply_stimulus("lockout", bit'($urandom_range(0, 1)), 0, int'($urandom_range(0, 9)),
                           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            if (bus.locked) lock_len++;
            if (bus.alarm) alarm_hi++;
        end
        cmp("lockout", "lock_len", 32'(lock_len), 32'(LC));
        cmp("lockout", "alarm_hi", 32'(alarm_hi), 32'(LC / 2));
        cmp("lockout", "err_after", 32'(bus.err_cnt), 32'd0);
        cmp("lockout", "alarm_after", 32'(bus.alarm), 32'd0);

        // Reset while open and while locked out wipes the passwords.
        type_code("rst_open", 1, 0, 24'h123456, 6);
        press("rst_open", 1, 0);
        apply_stimulus("rst_open", 1, 0, 0, 0, 0, 0);
        do_reset("rst_open");
        cmp("rst_open", "unlock", 32'(bus.unlock), 32'd0);
        type_code("post_rst", 1, 0, 24'h123456, 6);
        press("post_rst", 1, 0);
        cmp("post_rst", "err", 32'(bus.err_cnt), 32'd1);
        for (int k = 0; k < 2; k++) begin
            type_code("rst_lock", 1, 0, 24'h123456, 6);
            press("rst_lock", 1, 0);
        end
        cmp("rst_lock", "locked", 32'(bus.locked), 32'd1);
        for (int k = 0; k < 40; k++) apply_stimulus("rst_lock", 0, 0, 0, 0, 0, 0);
        do_reset("rst_lock");
        cmp("rst_lock", "locked_after", 32'(bus.locked), 32'd0);
        type_code("post_rst2", 1, 0, 24'h123456, 6);
        press("post_rst2", 1, 0);
        cmp("post_rst2", "err", 32'(bus.err_cnt), 32'd1);
        type_code("reprog", 0, 0, 24'h123456, 6);
        press("reprog", 0, 0);
        cmp("reprog", "prog", 32'(bus.prog_ok), 32'd1);

        // Random traffic, with the stored code typed now and then so opens still happen.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 4) begin
                type_code("rnd", 1, 0, 24'h123456, 6);
                press("rnd", 1, 0);
            end else begin
                apply_stimulus("rnd", bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                               int'($urandom_range(0, 11)), ($urandom_range(0, 99) < 50),
                               ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 8));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lock_ctrl_gen.md
# lock_ctrl_gen

Parametrised successor to the six-digit electronic lock controller. Digits are entered one at a time into a shift buffer of DIGITS positions, and the buffer is compared against up to SLOTS stored passwords. Programming is gated so that it only works while the lock is open or before any password exists. Failed attempts are counted, and MAX_ERR failures trigger a timed lockout with a flashing alarm. Sits between the keypad/switch front end and the seven-segment display and LED drivers.

## Interface
- DIGITS, 6, password length in BCD digits (≥2)
- SLOTS, 4, number of stored password slots (≥1)
- MAX_ERR, 3, consecutive failed checks that trigger lockout (≥1)
- OPEN_CYCLES, 256, cycles unlock stays high before auto-relock
- LOCK_CYCLES, 1024, cycles of lockout
- FLASH_HALF, 16, alarm half-period in cycles
- clk  in  1  single clock, all logic on rising edge
- clr_n  in  1  reset, asynchronous, active-low
- mode  in  1  0 = program, 1 = check
- slot  in  max(1,$clog2(SLOTS))  target slot for programming; values ≥ SLOTS are ignored
- digit  in  4  BCD digit
- digit_vld  in  1  one-cycle strobe, digit is valid
- clr  in  1  synchronous clear of the entry buffer
- enter  in  1  one-cycle strobe: commit (mode 0) or check (mode 1)
- disp  out  4*DIGITS  entry buffer; disp[3:0] holds the most recent digit
- unlock  out  1  lock open
- locked  out  1  lockout active
- alarm  out  1  flashing LED drive
- err_cnt  out  $clog2(MAX_ERR+1)  consecutive failures
- prog_ok  out  1  one-cycle pulse on a successful slot write

## Operation
- States:
  - IDLE: unlock=0, locked=0.
  - OPEN: unlock=1.
  - LOCKOUT: locked=1.
- Storage per slot: DIGITS×4-bit word plus a valid bit.
- Entry buffer:
  - Accepted only in IDLE or OPEN.
  - digit_vld with digit ≤ 9 and cnt < DIGITS: buf ← {buf[4*DIGITS-5:0], digit}, cnt+1.
  - digit > 9: ignored.
  - cnt == DIGITS: further digits ignored (no wrap).
- clr: buffer ← 0, cnt ← 0. Highest priority over digit_vld and enter in the same cycle. Ignored in LOCKOUT.
- enter with digit_vld in the same cycle: enter acts on the pre-digit buffer and the digit is dropped.
- Program (mode 0, enter):
  - Write proceeds only if all of: cnt == DIGITS; state is OPEN, or no slot is valid; slot < SLOTS.
  - Write: store buf into slot, set its valid bit, pulse prog_ok, clear buffer.
  - Otherwise no write and buffer unchanged.
  - Overwriting a valid slot is allowed.
- Check (mode 1, enter) in IDLE:
  - Match = cnt == DIGITS and buf equals any valid slot.
  - Match: go to OPEN, err_cnt ← 0.
  - Mismatch (including incomplete entry or no valid slot): err_cnt+1. If the new value equals MAX_ERR, go to LOCKOUT.
  - Buffer cleared in both cases.
- Check (mode 1, enter) in OPEN: manual relock to IDLE, buffer cleared.
- OPEN auto-relock: after OPEN_CYCLES cycles, go to IDLE.
- LOCKOUT:
  - digit_vld, enter, clr and mode are all ignored.
  - disp is forced to all 4'hE.
  - alarm toggles every FLASH_HALF cycles, starting at 1.
  - After LOCK_CYCLES cycles: go to IDLE, err_cnt ← 0, alarm ← 0, buffer cleared.
- alarm is 0 outside LOCKOUT.
- Timers are reloaded on each state entry and never run in IDLE.

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE.
  - disp, err_cnt, unlock, locked, alarm, prog_ok all 0.
  - All slots 0 with valid bits cleared.
  - cnt 0, timers 0.
- disp updates the cycle after digit_vld or clr.
- unlock, locked and prog_ok assert the cycle after the enter edge.
- err_cnt updates the cycle after the enter edge.
- unlock stays high for exactly OPEN_CYCLES cycles unless a manual relock occurs.
- locked stays high for exactly LOCK_CYCLES cycles.
- alarm period is 2×FLASH_HALF cycles.
- Reset mid-operation (any state, including LOCKOUT): returns immediately to the reset values and erases all passwords.
- err_cnt saturates at MAX_ERR. It is reset only by a match, by lockout expiry, or by reset.

## Test plan
- Reset, then mode 0, slot 0, enter digits 1,2,3,4,5,6 and enter → prog_ok pulse, slot 0 valid, disp 0. Then mode 1, same digits, enter → unlock=1 next cycle and held exactly 256 cycles.
- With slot 0 = 123456, attempt to program slot 1 while IDLE → no prog_ok. Same write while OPEN → prog_ok; 654321 then opens.
- Three checks with 111111 → err_cnt 1,2,3; locked=1; disp all E; alarm toggles every 16 cycles. Digits and enter are ignored during lockout. Exactly 1024 cycles later: IDLE, err_cnt 0, alarm 0.
- Enter 7 digits and a digit 0xA: buffer holds the first 6 valid digits. Check with only 5 digits → counted as a failure.
- clr, digit_vld and enter in the same cycle → buffer 0, no check. Enter and digit_vld in the same cycle → check uses the old buffer and the digit is dropped.
- Assert clr_n low during OPEN and during LOCKOUT → all outputs 0 immediately. Any subsequent check fails, since no slot is valid.
